// File: rtl/unidad_saltos_pkg.sv
// Shared encodings for the branch/return-stack unit:
// operation codes, condition codes and flag bit positions.
package unidad_saltos_pkg;

    typedef enum logic [2:0] {
        OP_NEXT = 3'b000,
        OP_JMP  = 3'b001,
        OP_JR   = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100
    } op_e;

    localparam logic [2:0] CO_SIEMPRE0 = 3'b000;
    localparam logic [2:0] CO_SIEMPRE1 = 3'b001;
    localparam logic [2:0] CO_Z        = 3'b010;
    localparam logic [2:0] CO_NZ       = 3'b011;
    localparam logic [2:0] CO_C        = 3'b100;
    localparam logic [2:0] CO_NC       = 3'b101;
    localparam logic [2:0] CO_N        = 3'b110;
    localparam logic [2:0] CO_NN       = 3'b111;

    localparam int BAND_Z = 0;
    localparam int BAND_C = 1;
    localparam int BAND_N = 2;

    function automatic logic eval_cond(input logic [2:0] c,
                                       input logic [2:0] b);
        logic r;
        r = 1'b1;
        case (c)
            CO_Z:    r =  b[BAND_Z];
            CO_NZ:   r = ~b[BAND_Z];
            CO_C:    r =  b[BAND_C];
            CO_NC:   r = ~b[BAND_C];
            CO_N:    r =  b[BAND_N];
            CO_NN:   r = ~b[BAND_N];
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/unidad_saltos_pila_if.sv
// Link between the PC control logic and the return stack.
// master = controller, slave = LIFO.
interface unidad_saltos_pila_if #(
    parameter int ADDR_W = 8
);
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] dato_in;
    logic [ADDR_W-1:0] dato_out;
    logic              llena;
    logic              vacia;

    modport master (
        output push, pop, dato_in,
        input  dato_out, llena, vacia
    );

    modport slave (
        input  push, pop, dato_in,
        output dato_out, llena, vacia
    );
endinterface

// File: rtl/pila_retorno.sv
// Return-address LIFO. Count pointer is one bit wider than
// the index so full and empty never alias.
module pila_retorno
    import unidad_saltos_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int PILA_PROF = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    unidad_saltos_pila_if.slave    p
);

    localparam int IW = $clog2(PILA_PROF);
    localparam int PW = IW + 1;

    logic [ADDR_W-1:0] mem_q [PILA_PROF];
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic [IW-1:0]     idx_wr;
    logic [IW-1:0]     idx_top;

    assign idx_wr  = ptr_q[IW-1:0];
    assign idx_top = ptr_q[IW-1:0] - IW'(1);

    assign p.dato_out = mem_q[idx_top];
    assign p.llena    = (ptr_q == PW'(PILA_PROF));
    assign p.vacia    = (ptr_q == '0);

    // Next count: parent never raises push and pop together.
    always_comb begin
        ptr_d = ptr_q;
        if (p.push && !p.llena) begin
            ptr_d = ptr_q + PW'(1);
        end else if (p.pop && !p.vacia) begin
            ptr_d = ptr_q - PW'(1);
        end
    end

    // Count register; reset empties the stack.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Entry storage, no reset needed.
    always_ff @(posedge clk_i) begin
        if (p.push && !p.llena) begin
            mem_q[idx_wr] <= p.dato_in;
        end
    end

endmodule

// File: rtl/unidad_saltos_pila.sv
// Program counter with conditional jumps, relative branches
// and CALL/RET through a hardware return stack.
module unidad_saltos_pila
    import unidad_saltos_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int PILA_PROF = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Habilitar,
    input  logic [2:0]        Operacion,
    input  logic [2:0]        Condicion,
    input  logic [2:0]        Banderas,
    input  logic [ADDR_W-1:0] Direccion_de_Salto,
    output logic [ADDR_W-1:0] o_Bus_Direcciones_Instrucciones,
    output logic              o_Salto_Tomado,
    output logic              o_Pila_Llena,
    output logic              o_Pila_Vacia,
    output logic              o_Error_Pila
);

    unidad_saltos_pila_if #(.ADDR_W(ADDR_W)) pila ();

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              salto_q, salto_d;
    logic              err_q, err_d;
    logic              cond;
    logic              push, pop;

    pila_retorno #(
        .ADDR_W   (ADDR_W),
        .PILA_PROF(PILA_PROF)
    ) u_pila (
        .clk_i (Clk),
        .rst_ni(Rst),
        .p     (pila.slave)
    );

    assign cond         = eval_cond(Condicion, Banderas);
    assign pc_inc       = pc_q + ADDR_W'(1);
    assign pila.push    = push;
    assign pila.pop     = pop;
    assign pila.dato_in = pc_inc;

    // Next PC, stack requests, taken flag and sticky error.
    always_comb begin
        pc_d    = pc_inc;
        salto_d = 1'b0;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (!Habilitar) begin
            pc_d = pc_q;
        end else if (cond) begin
            case (Operacion)
                OP_JMP: begin
                    pc_d    = Direccion_de_Salto;
                    salto_d = 1'b1;
                end
                OP_JR: begin
                    pc_d    = pc_q + Direccion_de_Salto;
                    salto_d = 1'b1;
                end
                OP_CALL: begin
                    if (pila.llena) begin
                        err_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pc_d    = Direccion_de_Salto;
                        salto_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (pila.vacia) begin
                        err_d = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pc_d    = pila.dato_out;
                        salto_d = 1'b1;
                    end
                end
                default: pc_d = pc_inc;
            endcase
        end
    end

    // Architectural registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            pc_q    <= '0;
            salto_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            salto_q <= salto_d;
            err_q   <= err_d;
        end
    end

    assign o_Bus_Direcciones_Instrucciones = pc_q;
    assign o_Salto_Tomado = salto_q;
    assign o_Pila_Llena   = pila.llena;
    assign o_Pila_Vacia   = pila.vacia;
    assign o_Error_Pila   = err_q;

endmodule
